// File: rtl/instruction_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_prefetch_pkg
// Description : Shared types and constants for the instruction prefetch unit.
//               Defines the fetch FSM state encoding, the instruction and PC
//               width, the PC step, and small PC helper functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_prefetch_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] PC_INC = 16'h0002;

  // Explicitly encoded 2-bit fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Next sequential instruction address; wraps FFFE -> 0000 in 16 bits.
  function automatic logic [DATA_W-1:0] pc_plus_inc(input logic [DATA_W-1:0] pc);
    return pc + PC_INC;
  endfunction

  // Instructions are halfword aligned: bit 0 of any target is forced to 0.
  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:1], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Power-of-two deep register FIFO holding prefetched entries.
//               The head entry is read straight from the storage registers,
//               so the output never has a combinational path from din.
//               Flush has priority over push and pop in the same cycle.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-low reset
//               push   - write din at tail (ignored when full)
//               din    - entry to write
//               pop    - advance head (ignored when empty)
//               flush  - empty the FIFO at the next edge
//               head   - entry at head (registered)
//               full   - count == DEPTH
//               empty  - count == 0
//               count  - number of valid entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic w_push;
  logic w_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_prefetch
// Description : Instruction prefetch unit. Issues one outstanding halfword
//               read at a time, queues {instruction, pc+2} entries in a FIFO
//               and presents the head entry to the IF/ID consumer. Redirects
//               flush the queue and restart fetching at the new target; an
//               in-flight read at redirect time is drained and dropped.
// Ports       : clock         - rising-edge clock
//               reset         - asynchronous active-low reset
//               mem_req       - instruction memory read request
//               mem_addr      - byte address of the request
//               mem_ack       - read complete, mem_data valid
//               mem_data      - instruction word
//               redirect      - taken branch/jump, restart fetch
//               redirect_addr - new fetch address (bit 0 ignored)
//               halt          - stop issuing new requests
//               hold          - consumer stall, do not pop
//               inst_valid    - head entry valid
//               inst          - head instruction
//               inst_pc_next  - head instruction address + 2
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_prefetch
  import instruction_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  input  logic        halt,
  input  logic        hold,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc_next
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;

  logic [2*DATA_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_post;
  logic [DATA_W-1:0] w_target;

  assign w_target = align_pc(redirect_addr);

  // Only data returned for a live (non-discarded) request is queued, and a
  // redirect in the same cycle drops it.
  assign w_push = (state_q == ST_REQ) & mem_ack & ~redirect;
  assign w_pop  = inst_valid & ~hold;

  // Occupancy as it will be after this edge, used to decide whether the
  // next back-to-back request may be issued without overflowing.
  always_comb begin
    w_count_post = fifo_count;
    if (redirect) begin
      w_count_post = '0;
    end else if (w_push && !w_pop) begin
      w_count_post = fifo_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_post = fifo_count - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    if (redirect) begin
      fetch_pc_d = w_target;
    end
    case (state_q)
      ST_IDLE: begin
        // A redirect flushes the queue, so there is always room for it.
        if (!halt && (redirect || !fifo_full)) begin
          state_d    = ST_REQ;
          mem_addr_d = fetch_pc_d;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!redirect) begin
            fetch_pc_d = pc_plus_inc(fetch_pc_q);
          end
          if (!halt && (w_count_post != FULL_CNT)) begin
            state_d    = ST_REQ;
            mem_addr_d = fetch_pc_d;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect) begin
          // Keep the old address on the bus until the memory answers.
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        // The stale ack ends the discarded transaction. A redirect arriving
        // together with it only retargets the next fetch; staying here would
        // wait for an ack that never comes.
        if (mem_ack) begin
          if (halt) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_REQ;
            mem_addr_d = fetch_pc_d;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .din   ({mem_data, pc_plus_inc(mem_addr_q)}),
    .pop   (w_pop),
    .flush (redirect),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mem_req      = (state_q != ST_IDLE);
  assign mem_addr     = mem_addr_q;
  assign inst_valid   = ~fifo_empty;
  assign inst         = fifo_head[2*DATA_W-1:DATA_W];
  assign inst_pc_next = fifo_head[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_prefetch
// Description : Self-checking bench for instruction_prefetch. A memory model
//               answers requests after a programmable number of wait cycles;
//               accepted read data is pushed to a scoreboard queue and
//               compared against the head entry when it is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        halt = 1'b0;
  logic        hold = 1'b0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc_next;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  bit          discard_m = 1'b0;
  int          wait_cnt  = 0;
  int          mem_wait  = 0;
  int          acks      = 0;

  instruction_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .hold          (hold),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc_next  (inst_pc_next)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // One clock cycle: memory response at the falling edge, scoreboard update
  // for what the coming rising edge will do, then advance past that edge.
  task automatic cycle();
    logic [31:0] exp;
    logic        exp_valid;
    @(negedge clock);
    if (mem_req && wait_cnt >= mem_wait) begin
      mem_ack  = 1'b1;
      mem_data = mem_word(mem_addr);
    end else begin
      mem_ack  = 1'b0;
      mem_data = 16'hDEAD;
    end
    exp_valid = (sb_q.size() != 0);
    checks++;
    if (inst_valid !== exp_valid) begin
      errors++;
      $display("FAIL sb_valid: inst_valid=%b expected %b", inst_valid, exp_valid);
    end
    if (redirect) begin
      sb_q.delete();
      if (mem_req && !mem_ack) discard_m = 1'b1;
    end else begin
      if (inst_valid && !hold && sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checks++;
        if ({inst, inst_pc_next} !== exp) begin
          errors++;
          $display("FAIL sb_head: inst/pc_next=%h/%h expected %h/%h",
                   inst, inst_pc_next, exp[31:16], exp[15:0]);
        end
      end
      if (mem_req && mem_ack && !discard_m) begin
        sb_q.push_back({mem_word(mem_addr), mem_addr + 16'h0002});
        acks++;
      end
    end
    if (mem_req && mem_ack) begin
      discard_m = 1'b0;
      wait_cnt  = 0;
    end else if (mem_req) begin
      wait_cnt++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    hold     = 1'b0;
    mem_ack  = 1'b0;
    sb_q.delete();
    discard_m = 1'b0;
    wait_cnt  = 0;
    mem_wait  = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({mem_req, inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: req/valid=%b%b expected 00", mem_req, inst_valid);
    end
    checks++;
    if ({mem_addr, inst, inst_pc_next} !== {RESET_PC, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: addr/inst/pcn=%h/%h/%h expected %h/0000/0000",
               mem_addr, inst, inst_pc_next, RESET_PC);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycle();
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === RESET_PC)) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h expected 1 %h", mem_req, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_addr !== 16'(2 * k)) begin
        errors++;
        $display("FAIL seq_addr: addr=%h expected %h", mem_addr, 16'(2 * k));
      end
      cycle();
      checks++;
      if (!(inst_valid === 1'b1 && inst_pc_next === 16'(2 * k + 2))) begin
        errors++;
        $display("FAIL seq_head: valid=%b pcn=%h expected 1 %h",
                 inst_valid, inst_pc_next, 16'(2 * k + 2));
      end
    end
  endtask

  task automatic test_hold();
    bit found;
    do_reset();
    hold = 1'b1;
    acks = 0;
    repeat (10) cycle();
    checks++;
    if (acks != DEPTH || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_fill: acks=%0d req=%b expected %0d 0", acks, mem_req, DEPTH);
    end
    hold  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (mem_req) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || mem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL hold_resume: req_seen=%b addr=%h expected 1 0008", found, mem_addr);
    end
    repeat (8) cycle();
  endtask

  task automatic test_redirect_pending();
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_addr == 16'h0006) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_setup: req at 0006 not seen, addr=%h", mem_addr);
    end
    mem_wait = 3;
    cycle();
    redirect      = 1'b1;
    redirect_addr = 16'h0041;
    cycle();
    redirect = 1'b0;
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === 16'h0006 && inst_valid === 1'b0)) begin
      errors++;
      $display("FAIL redir_discard: req=%b addr=%h valid=%b expected 1 0006 0",
               mem_req, mem_addr, inst_valid);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (mem_addr != 16'h0006) break;
    end
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === 16'h0040)) begin
      errors++;
      $display("FAIL redir_target: req=%b addr=%h expected 1 0040", mem_req, mem_addr);
    end
    mem_wait = 0;
    cycle();
    checks++;
    if (!(inst_valid === 1'b1 && inst === mem_word(16'h0040) && inst_pc_next === 16'h0042)) begin
      errors++;
      $display("FAIL redir_first: valid=%b inst=%h pcn=%h expected 1 %h 0042",
               inst_valid, inst, inst_pc_next, mem_word(16'h0040));
    end
    repeat (4) cycle();
  endtask

  task automatic test_redirect_ack();
    redirect      = 1'b1;
    redirect_addr = 16'h1234;
    cycle();
    redirect = 1'b0;
    checks++;
    if (!(inst_valid === 1'b0 && mem_req === 1'b1 && mem_addr === 16'h1234)) begin
      errors++;
      $display("FAIL redir_ack: valid=%b req=%b addr=%h expected 0 1 1234",
               inst_valid, mem_req, mem_addr);
    end
    cycle();
    checks++;
    if (inst_pc_next !== 16'h1236) begin
      errors++;
      $display("FAIL redir_ack_next: pcn=%h expected 1236", inst_pc_next);
    end
    repeat (3) cycle();
  endtask

  task automatic test_wrap();
    hold          = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 16'hFFFF;
    cycle();
    redirect = 1'b0;
    checks++;
    if (mem_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_align: addr=%h expected FFFE", mem_addr);
    end
    cycle();
    checks++;
    if (!(inst_valid === 1'b1 && inst_pc_next === 16'h0000 && mem_addr === 16'h0000)) begin
      errors++;
      $display("FAIL wrap: valid=%b pcn=%h addr=%h expected 1 0000 0000",
               inst_valid, inst_pc_next, mem_addr);
    end
    hold = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (sb_q.size() == 3) break;
    end
    mem_wait = 100;
    cycle();
    checks++;
    if (!(mem_req === 1'b1 && inst_valid === 1'b1 && sb_q.size() == 3)) begin
      errors++;
      $display("FAIL rstmid_setup: req=%b valid=%b entries=%0d expected 1 1 3",
               mem_req, inst_valid, sb_q.size());
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (!(mem_req === 1'b0 && inst_valid === 1'b0 && mem_addr === RESET_PC)) begin
      errors++;
      $display("FAIL rstmid_async: req=%b valid=%b addr=%h expected 0 0 %h",
               mem_req, inst_valid, mem_addr, RESET_PC);
    end
    sb_q.delete();
    discard_m = 1'b0;
    wait_cnt  = 0;
    hold      = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    // Late ack while no request is outstanding must be ignored.
    @(negedge clock);
    mem_ack  = 1'b1;
    mem_data = 16'hBAD0;
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === RESET_PC && inst_valid === 1'b0)) begin
      errors++;
      $display("FAIL rstmid_release: req=%b addr=%h valid=%b expected 1 %h 0",
               mem_req, mem_addr, inst_valid, RESET_PC);
    end
    mem_wait = 0;
    cycle();
    checks++;
    if (!(inst_valid === 1'b1 && inst_pc_next === 16'h0002)) begin
      errors++;
      $display("FAIL rstmid_first: valid=%b pcn=%h expected 1 0002", inst_valid, inst_pc_next);
    end
    repeat (4) cycle();
  endtask

  task automatic test_halt();
    mem_wait = 2;
    acks     = 0;
    halt     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!mem_req) break;
    end
    checks++;
    if (!(acks == 1 && mem_req === 1'b0)) begin
      errors++;
      $display("FAIL halt_pending: acks=%0d req=%b expected 1 0", acks, mem_req);
    end
    repeat (3) cycle();
    checks++;
    if (!(mem_req === 1'b0 && inst_valid === 1'b0)) begin
      errors++;
      $display("FAIL halt_drain: req=%b valid=%b expected 0 0", mem_req, inst_valid);
    end
    halt     = 1'b0;
    mem_wait = 0;
    repeat (4) cycle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect_pending();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
